pe_mac_ctrl: RTL and testbench
==============================

# pe_mac_ctrl

Sequencer for a single MAC processing element. Loads a weight, accepts `len` activations over a valid/ready stream, and generates the register enables for the PE's activation and accumulator registers. Presents the finished accumulation with a valid/ready result handshake. Sits between the NPU job dispatcher and one PE datapath (weight reg, activation reg, 1-cycle multiplier, accumulator reg).

## Interface
- `LEN_W`, 8, width of step count; max job length 2^LEN_W-1
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: job request; sampled only in IDLE
- `len` in LEN_W: number of MAC steps, sampled with `start`
- `a_valid` in 1: activation word present on PE input
- `a_ready` out 1: controller accepts activation this cycle
- `out_ready` in 1: consumer accepts result
- `out_valid` out 1: accumulator holds final result
- `w_en` out 1: load enable for the PE weight register
- `x_en` out 1: load enable for the PE activation register
- `acc_clr` out 1: synchronous clear of the accumulator register
- `acc_en` out 1: accumulate enable (acc <= acc + product)
- `busy` out 1: high in every state except IDLE
- `cnt` out LEN_W: activations accepted in current job

## Operation
- States: IDLE, RUN, DRAIN, DONE (state register plus `len_q`, `cnt`, `pend_q`).
- IDLE: `a_ready`=0. On `start`=1, assert `w_en`=1 and `acc_clr`=1 combinationally in the same cycle, latch `len` into `len_q`, and clear `cnt`. Next state is RUN if `len`!=0, otherwise DONE.
- RUN: `a_ready`=1.
  - A handshake (`a_valid`&`a_ready`) asserts `x_en`=1 in the same cycle and increments `cnt`.
  - If the handshake makes `cnt`==`len_q`, the next state is DRAIN.
- `pend_q` <= handshake, every cycle. `acc_en` = `pend_q`, so each accumulate occurs one cycle after its activation load to cover multiplier latency.
- DRAIN: `a_ready`=0. Lasts exactly one cycle, during which the final `acc_en` fires. Next state is DONE.
- DONE: `out_valid`=1 and holds until `out_ready`=1; then next state is IDLE. Result data is the accumulator itself; the controller does not touch it in DONE.
- `start` outside IDLE is ignored, including `start` in the same cycle as the DONE->IDLE handshake.
- `cnt` never exceeds `len_q`; no wrap.
- Reset mid-job: abandon immediately. The job is not resumed.

## Timing
- Reset values: state IDLE; `cnt`=0, `len_q`=0, `pend_q`=0; all outputs 0.
- `a_valid` held high, `start` at cycle 0: handshakes at cycles 1..len, DRAIN at len+1, `out_valid` rises at cycle len+2. Start-to-result latency is len+2 cycles.
- `a_valid` gaps stall RUN with no counting and no `acc_en` one cycle later. Latency grows by the number of gap cycles.
- `len`=0: `out_valid` at cycle 1, with the accumulator cleared at cycle 0.
- Back-to-back jobs: earliest next `start` is the cycle after the `out_ready` handshake.
- `w_en`, `x_en`, `acc_clr`, and `a_ready` are combinational from state/inputs. `acc_en`, `out_valid`, `busy`, and `cnt` are decoded from registers only.

## Structure
- Package `pe_pkg`: `typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pe_state_t`, and `PE_LEN_W` default constant.
- The `len_q` latch uses the existing `regN` (WIDTH=LEN_W, en = IDLE&`start`). Note: `regN` has a synchronous reset, so drive its `rst` from the synchronized reset or accept a 1-cycle reset skew; `len_q` is don't-care in IDLE.
- Counter, FSM, and `pend_q` are inline. No other sub-modules.

## Test plan
- Reset asserted asynchronously mid-RUN (len=5, cnt=3) -> all outputs 0 without a clock edge; IDLE after release; next `start` runs a full 5-step job.
- len=4, `a_valid` constant, `out_ready`=1 -> `x_en` at cycles 1-4, `acc_en` at 2-5, `out_valid` only at cycle 6, `cnt`=4.
- len=3, `a_valid` pattern 1,0,0,1,1 -> three `x_en` pulses aligned to valid cycles, three `acc_en` pulses each one cycle later, `out_valid` at cycle 7.
- len=0 -> `w_en` and `acc_clr` at cycle 0, no `x_en`/`acc_en`, `out_valid` at cycle 1.
- DONE with `out_ready`=0 for 5 cycles, then 1 together with `start` -> `out_valid` held 6 cycles, `start` ignored, IDLE next; a `start` one cycle later is accepted.
- `start` pulsed during RUN with a different `len` -> ignored; `len_q` and job length unchanged.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and defaults for the MAC processing-element sequencer.
package pe_pkg;

  localparam int PE_LEN_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pe_state_t;

endpackage

// File: rtl/pe_mac_ctrl_regn.sv
// Generic N-bit load-enable register with synchronous reset (regN).
module regN #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pe_mac_ctrl.sv
// Sequencer for one MAC PE: weight load, len activation handshakes,
// accumulate enables delayed one cycle for the multiplier, result handshake.
module pe_mac_ctrl
  import pe_pkg::*;
#(
  parameter int LEN_W = PE_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             w_en,
  output logic             x_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             busy,
  output logic [LEN_W-1:0] cnt,
  output pe_state_t        dbg_state
);

  // Handshakes: an activation transfers when a_valid && a_ready in the same
  // cycle; a result transfers when out_valid && out_ready in the same cycle.
  // Neither side may make its valid depend on the other side's ready.

  pe_state_t        state, next_state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_inc;
  logic             pend_q;
  logic             hs;
  logic             load;

  assign cnt_inc = cnt_q + LEN_W'(1);
  assign hs      = a_valid & a_ready;

  // len_q is only consulted in RUN, so its sync-reset skew is harmless.
  regN #(.WIDTH(LEN_W)) u_len_reg (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   (len),
    .q   (len_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      state  <= next_state;
      pend_q <= hs;
      if (load) begin
        cnt_q <= '0;
      end else if (hs) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  always_comb begin
    next_state = state;
    a_ready    = 1'b0;
    w_en       = 1'b0;
    acc_clr    = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        // Gated by rst so the combinational enables read 0 during reset.
        if (start && !rst) begin
          w_en       = 1'b1;
          acc_clr    = 1'b1;
          load       = 1'b1;
          next_state = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        a_ready = 1'b1;
        if (a_valid && (cnt_inc == len_q)) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = DONE;
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign x_en      = hs;
  assign acc_en    = pend_q;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign cnt       = cnt_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// Directed and randomized checks of pe_mac_ctrl against a cycle-indexed
// reference derived from the job's handshake schedule.
module tb_pe_mac_ctrl;
  import pe_pkg::*;

  localparam int LEN_W = 8;
  localparam int MAXC  = 300;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             a_valid;
  logic             a_ready;
  logic             out_ready;
  logic             out_valid;
  logic             w_en;
  logic             x_en;
  logic             acc_clr;
  logic             acc_en;
  logic             busy;
  logic [LEN_W-1:0] cnt;
  pe_state_t        dbg_state;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   prev_cnt = 0;
  logic vs [0:MAXC-1];

  pe_mac_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .w_en      (w_en),
    .x_en      (x_en),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .busy      (busy),
    .cnt       (cnt),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_all(input bit e_ready, input bit e_x, input bit e_w, input bit e_clr,
                           input bit e_acc, input bit e_ov, input bit e_busy, input int e_cnt);
    chk("a_ready",   32'(a_ready),   32'(e_ready));
    chk("x_en",      32'(x_en),      32'(e_x));
    chk("w_en",      32'(w_en),      32'(e_w));
    chk("acc_clr",   32'(acc_clr),   32'(e_clr));
    chk("acc_en",    32'(acc_en),    32'(e_acc));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("cnt",       32'(cnt),       32'(e_cnt));
  endtask

  // mode 0: a_valid always high; mode 1: random gaps for the first 40 cycles
  task automatic fill_valid(input int mode);
    for (int t = 0; t < MAXC; t++) begin
      vs[t] = (mode == 0 || t >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      start     = 1'b0;
      len       = LEN_W'($urandom_range(0, 255));
      a_valid   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check_all(0, 0, 0, 0, 0, 0, 0, prev_cnt);
    end
  endtask

  // One job: start at local cycle 0, activations accepted on the first jl
  // cycles >= 1 where vs is high, result held rd extra cycles before out_ready.
  task automatic run_job(input int jl, input int rd, input bit start_at_end, input int abort_at);
    bit hs_at [0:MAXC-1];
    int n_before [0:MAXC-1];
    int hs_cnt, last, done_start, done_end;
    hs_cnt = 0;
    last   = 0;
    for (int t = 0; t < MAXC; t++) begin
      hs_at[t]    = 1'b0;
      n_before[t] = hs_cnt;
      if (t >= 1 && hs_cnt < jl && vs[t] == 1'b1) begin
        hs_at[t] = 1'b1;
        hs_cnt++;
        last = t;
      end
    end
    done_start = (jl == 0) ? 1 : last + 2;
    done_end   = done_start + rd;
    for (int t = 0; t <= done_end; t++) begin
      @(posedge clk); #1;
      cyc++;
      if (t == 0) start = 1'b1;
      else if (t == done_end && start_at_end) start = 1'b1;
      else start = ($urandom_range(0, 3) == 0);
      len       = (t == 0) ? LEN_W'(jl) : LEN_W'($urandom_range(0, 255));
      a_valid   = (t >= 1 && t <= last) ? vs[t] : 1'($urandom_range(0, 1));
      out_ready = (t == done_end) ? 1'b1 : (t >= done_start) ? 1'b0 : 1'($urandom_range(0, 1));
      if (t == abort_at) begin
        rst = 1'b1;
        #1;
        check_all(0, 0, 0, 0, 0, 0, 0, 0);
        prev_cnt = 0;
        return;
      end
      #1;
      check_all(jl > 0 && t >= 1 && t <= last, hs_at[t], t == 0, t == 0,
                (t >= 1) ? hs_at[t-1] : 1'b0, t >= done_start, t >= 1,
                (t == 0) ? prev_cnt : n_before[t]);
    end
    prev_cnt = jl;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; a_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // asynchronous reset mid-RUN with cnt=3, then a full 5-step job
    fill_valid(0);
    run_job(5, 0, 1'b0, 4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);
    run_job(5, 1, 1'b0, -1);

    // len=4, continuous a_valid
    run_job(4, 0, 1'b0, -1);
    idle_cycles(1);

    // len=3 with a_valid pattern 1,0,0,1,1
    fill_valid(0);
    vs[2] = 1'b0;
    vs[3] = 1'b0;
    run_job(3, 0, 1'b0, -1);

    // len=0
    run_job(0, 0, 1'b0, -1);

    // held result for 5 cycles, start ignored on the handshake, then accepted
    fill_valid(1);
    run_job(2, 5, 1'b1, -1);
    run_job(3, 0, 1'b0, -1);

    // maximum job length
    fill_valid(0);
    run_job(255, 1, 1'b0, -1);

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      fill_valid(1);
      run_job($urandom_range(0, 12), $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
